// File: rtl/dm_port_arbiter_if.sv
// Bus bundles for dm_port_arbiter.
// dm_port_arbiter_if: one requester port (P or D); master = requester, slave = arbiter.
//   req/we/size/addr/wdata/lock in, gnt out; rsp/err/rdata response one cycle after gnt.
// dm_port_arbiter_mem_if: data-memory port; master = arbiter, slave = memory.
//   en/we/be/addr/wdata out, rdata back one cycle after a read enable.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic              lock;
    logic              gnt;
    logic              rsp;
    logic              err;
    logic [63:0]       rdata;

    modport master (
        output req, we, size, addr, wdata, lock,
        input  gnt, rsp, err, rdata
    );
    modport slave (
        input  req, we, size, addr, wdata, lock,
        output gnt, rsp, err, rdata
    );
endinterface

interface dm_port_arbiter_mem_if #(
    parameter int ADDR_W = 32
);
    logic              en;
    logic              we;
    logic [7:0]        be;
    logic [ADDR_W-4:0] addr;
    logic [63:0]       wdata;
    logic [63:0]       rdata;

    modport master (
        output en, we, be, addr, wdata,
        input  rdata
    );
    modport slave (
        input  en, we, be, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the 64-bit data-memory port between MEM stage (p) and DMA/debug (d).
// Ports: i_clk, i_rst (sync, active-high), p/d requester bundles (slave), dm memory bundle (master).
// P has fixed priority; a starvation counter lets D win after STARVE_LIMIT lost cycles.
// Optional macro DM_ARB_LOCK_EN: D may lock the port for atomic read-modify-write.
module dm_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    dm_port_arbiter_if.slave       p,
    dm_port_arbiter_if.slave       d,
    dm_port_arbiter_mem_if.master  dm
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;
    logic          p_rsp_q, d_rsp_q, err_q, rd_q;
    logic          lock_held;

`ifdef DM_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic unused_lock;
    assign lock_held   = lock_q;
    assign unused_lock = p.lock;
`else
    logic unused_lock;
    assign lock_held   = 1'b0;
    assign unused_lock = p.lock ^ d.lock;
`endif

    logic              p_win, d_win, any, ok, go;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [63:0]       sel_wdata;
    logic [2:0]        off;
    logic [7:0]        mask, be_full;
    logic [63:0]       lane;

    always_comb begin
        // Outputs are forced idle while reset is asserted.
        d_win = !i_rst && d.req && (!p.req || starve_q == LIMIT || lock_held);
        p_win = !i_rst && p.req && !d_win && !lock_held;
        any   = p_win || d_win;

        sel_we    = d_win ? d.we    : p.we;
        sel_size  = d_win ? d.size  : p.size;
        sel_addr  = d_win ? d.addr  : p.addr;
        sel_wdata = d_win ? d.wdata : p.wdata;
        off       = sel_addr[2:0];

        mask = 8'hFF;
        ok   = 1'b0;
        unique case (sel_size)
            2'd0: begin mask = 8'h01; ok = 1'b1; end
            2'd1: begin mask = 8'h03; ok = !off[0]; end
            2'd2: begin mask = 8'h0F; ok = (off[1:0] == 2'b00); end
            2'd3: begin mask = 8'hFF; ok = (off == 3'b000); end
        endcase

        go      = any && ok;
        be_full = mask << off;
        lane    = '0;
        for (int k = 0; k < 8; k++)
            lane[8*k +: 8] = {8{be_full[k]}};

        dm.en    = go;
        dm.we    = go && sel_we;
        dm.be    = (go && sel_we) ? be_full : 8'h00;
        dm.addr  = go ? sel_addr[ADDR_W-1:3] : '0;
        dm.wdata = (go && sel_we) ? ((sel_wdata << {off, 3'b000}) & lane) : 64'h0;

        p.gnt = p_win;
        d.gnt = d_win;

        starve_d = starve_q;
        if (d_win)
            starve_d = '0;
        else if (d.req && starve_q != LIMIT)
            starve_d = starve_q + 1'b1;
    end

`ifdef DM_ARB_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        if (d_win)
            lock_d = d.lock;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_q <= '0;
            p_rsp_q  <= 1'b0;
            d_rsp_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            starve_q <= starve_d;
            p_rsp_q  <= p_win;
            d_rsp_q  <= d_win;
            err_q    <= any && !ok;
            rd_q     <= go && !sel_we;
        end
    end

`ifdef DM_ARB_LOCK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            lock_q <= 1'b0;
        else
            lock_q <= lock_d;
    end
`endif

    // Responses still in flight when reset rises are dropped.
    logic p_rsp, d_rsp;
    assign p_rsp   = p_rsp_q && !i_rst;
    assign d_rsp   = d_rsp_q && !i_rst;
    assign p.rsp   = p_rsp;
    assign d.rsp   = d_rsp;
    assign p.err   = p_rsp && err_q;
    assign d.err   = d_rsp && err_q;
    assign p.rdata = (p_rsp && rd_q) ? dm.rdata : 64'h0;
    assign d.rdata = (d_rsp && rd_q) ? dm.rdata : 64'h0;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios then random traffic
// against a byte-level reference model.
module tb_dm_port_arbiter;
    localparam int AW  = 32;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_port_arbiter_if #(.ADDR_W(AW)) p_if ();
    dm_port_arbiter_if #(.ADDR_W(AW)) d_if ();
    dm_port_arbiter_mem_if #(.ADDR_W(AW)) m_if ();

    dm_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .p     (p_if),
        .d     (d_if),
        .dm    (m_if)
    );

    int total = 0;
    int bad   = 0;

    int m_starve;
    bit m_lock, m_prsp, m_drsp, m_err, m_rd;

    bit          l_pg, l_dg, l_en, l_prsp, l_perr;
    logic [7:0]  l_be;
    logic [63:0] l_wd, l_prd;
    logic [28:0] l_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_mem(input bit we, input bit [1:0] sz, input bit [31:0] ad,
                           input bit [63:0] wd, output bit ok,
                           output bit [7:0] be, output bit [63:0] ewd);
        int n, o;
        n = 1 << sz;
        o = int'(ad[2:0]);
        ok = (ad % n) == 0;
        be = '0;
        ewd = '0;
        for (int k = 0; k < 8; k++)
            if (k >= o && k < o + n) begin
                be[k] = 1'b1;
                ewd[8*k +: 8] = wd[8*(k-o) +: 8];
            end
        if (!we) begin
            be = '0;
            ewd = '0;
        end
    endtask

    task automatic step();
        bit ep, ed, ok, we, go, erp, erd;
        bit [1:0] sz;
        bit [31:0] ad;
        bit [63:0] wd, ewd;
        bit [7:0] ebe;
        #3;
        ep = 0;
        ed = 0;
        if (!rst) begin
            if (m_lock) ed = d_if.req;
            else if (p_if.req && d_if.req) begin
                if (m_starve == LIM) ed = 1;
                else ep = 1;
            end else begin
                ep = p_if.req;
                ed = d_if.req;
            end
        end
        we = ed ? d_if.we    : p_if.we;
        sz = ed ? d_if.size  : p_if.size;
        ad = ed ? d_if.addr  : p_if.addr;
        wd = ed ? d_if.wdata : p_if.wdata;
        exp_mem(we, sz, ad, wd, ok, ebe, ewd);
        go = (ep || ed) && ok;
        chk("p_gnt", p_if.gnt, ep);
        chk("d_gnt", d_if.gnt, ed);
        chk("dm_en", m_if.en, go);
        chk("dm_we", m_if.we, go && we);
        chk("dm_be", m_if.be, go ? ebe : 8'h0);
        chk("dm_addr", m_if.addr, go ? ad[31:3] : 29'h0);
        chk("dm_wdata", m_if.wdata, go ? ewd : 64'h0);
        erp = !rst && m_prsp;
        erd = !rst && m_drsp;
        chk("p_rsp", p_if.rsp, erp);
        chk("p_err", p_if.err, erp && m_err);
        chk("p_rdata", p_if.rdata, (erp && m_rd) ? m_if.rdata : 64'h0);
        chk("d_rsp", d_if.rsp, erd);
        chk("d_err", d_if.err, erd && m_err);
        chk("d_rdata", d_if.rdata, (erd && m_rd) ? m_if.rdata : 64'h0);
        l_pg = p_if.gnt; l_dg = d_if.gnt; l_en = m_if.en;
        l_be = m_if.be; l_wd = m_if.wdata; l_addr = m_if.addr;
        l_prsp = p_if.rsp; l_perr = p_if.err; l_prd = p_if.rdata;
        if (rst) begin
            m_starve = 0; m_lock = 0;
            m_prsp = 0; m_drsp = 0; m_err = 0; m_rd = 0;
        end else begin
            if (ed) m_starve = 0;
            else if (d_if.req && m_starve < LIM) m_starve++;
`ifdef DM_ARB_LOCK_EN
            if (ed) m_lock = d_if.lock;
`endif
            m_prsp = ep;
            m_drsp = ed;
            m_err = (ep || ed) && !ok;
            m_rd = go && !we;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pdone;
        bit ep4;
        rst = 1;
        p_if.req = 0; p_if.we = 0; p_if.size = 0; p_if.addr = 0; p_if.wdata = 0; p_if.lock = 0;
        d_if.req = 0; d_if.we = 0; d_if.size = 0; d_if.addr = 0; d_if.wdata = 0; d_if.lock = 0;
        m_if.rdata = 64'hDEAD_BEEF_0BAD_F00D;
        m_starve = 0; m_lock = 0; m_prsp = 0; m_drsp = 0; m_err = 0; m_rd = 0;
        step();
        chk("rst_gnt", l_pg, 0);
        step();
        rst = 0;

        // Aligned DW read
        p_if.req = 1; p_if.we = 0; p_if.size = 3; p_if.addr = 32'h10;
        step();
        chk("rd_gnt", l_pg, 1);
        chk("rd_en", l_en, 1);
        chk("rd_addr", l_addr, 29'h2);
        p_if.req = 0;
        m_if.rdata = 64'h1122_3344_5566_7788;
        step();
        chk("rd_rsp", l_prsp, 1);
        chk("rd_err", l_perr, 0);
        chk("rd_data", l_prd, 64'h1122_3344_5566_7788);

        // Byte store at offset 5
        p_if.req = 1; p_if.we = 1; p_if.size = 0; p_if.addr = 32'h5; p_if.wdata = 64'hAB;
        step();
        chk("sb_be", l_be, 8'h20);
        chk("sb_wd", l_wd, 64'h0000_AB00_0000_0000);

        // Misaligned HW read
        p_if.we = 0; p_if.size = 1; p_if.addr = 32'h3;
        m_if.rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        chk("sb_rsp", l_prsp, 1);
        chk("sb_err", l_perr, 0);
        chk("mis_gnt", l_pg, 1);
        chk("mis_en", l_en, 0);
        p_if.req = 0;
        step();
        chk("mis_rsp", l_prsp, 1);
        chk("mis_err", l_perr, 1);
        chk("mis_rd", l_prd, 64'h0);

        // Starvation: both request every cycle
        p_if.req = 1; p_if.size = 3; p_if.addr = 32'h40;
        d_if.req = 1; d_if.we = 0; d_if.size = 3; d_if.addr = 32'h80; d_if.lock = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            chk("starve_d", l_dg, (i % 9) == 8);
            chk("starve_p", l_pg, (i % 9) != 8);
        end

        // Reset drops an in-flight response
        d_if.req = 0;
        step();
        rst = 1; d_if.req = 1;
        step();
        chk("rst1_rsp", l_prsp, 0);
        chk("rst1_gnt", l_pg | l_dg, 0);
        rst = 0; p_if.req = 0; d_if.req = 0;
        step();
        chk("rst2_rsp", l_prsp, 0);
        chk("rst2_en", l_en, 0);

        // Lock sequence
        d_if.req = 1; d_if.we = 0; d_if.lock = 1; d_if.addr = 32'h8;
        step();
        chk("lk_dgnt", l_dg, 1);
        pdone = 0;
        for (int c = 1; c <= 4; c++) begin
            p_if.req = !pdone;
            d_if.req = (c == 3);
            d_if.we = 1; d_if.lock = 0;
`ifdef DM_ARB_LOCK_EN
            ep4 = (c == 4);
`else
            ep4 = (c == 1);
`endif
            step();
            pdone |= l_pg;
            chk("lk_pgnt", l_pg, ep4);
        end

        // Random traffic
        p_if.req = 0; d_if.req = 0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom % 100) == 0;
            if (!(p_if.req && !l_pg)) begin
                p_if.req = ($urandom % 3) != 0;
                p_if.we = $urandom % 2;
                p_if.size = 2'($urandom % 4);
                p_if.addr = $urandom;
                p_if.wdata = {$urandom, $urandom};
            end
            if (!(d_if.req && !l_dg) || ($urandom % 8) == 0) begin
                d_if.req = ($urandom % 2) != 0;
                d_if.we = $urandom % 2;
                d_if.size = 2'($urandom % 4);
                d_if.addr = $urandom;
                d_if.wdata = {$urandom, $urandom};
            end
            d_if.lock = ($urandom % 4) == 0;
            m_if.rdata = {$urandom, $urandom};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
